seg_chase_ctrl: RTL
===================

SEG_CHASE_CTRL -- requirements
Module: seg_chase_ctrl

Interface
REQ-001 SHALL have parameter BASE_TICK, default 12_500_000, meaning clock cycles per chase step at iSPEED=0 (minimum 8).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: iCLK_50 input 1, 50 MHz system clock; iRST_N input 1, asynchronous active-low reset.
REQ-003 SHALL have iSTART input 1: request to start a chase from position 0.
REQ-004 SHALL have iSTOP input 1: request to stop and blank the display.
REQ-005 SHALL have iHOLD input 1: level; while high, the chase freezes.
REQ-006 SHALL have iDIR input 1: 0 = forward, 1 = reverse.
REQ-007 SHALL have iSPEED input 2: step period = BASE_TICK >> iSPEED.
REQ-008 SHALL have oHEX0_D..oHEX3_D outputs 7 each: active-low segment drives, bit0 = seg a ... bit6 = seg g.
REQ-009 SHALL have oBUSY output 1: high in RUN or PAUSE.
REQ-010 SHALL have oWRAP output 1: one-cycle pulse on each 24-position wrap.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and PAUSE.
REQ-012 SHALL track the chase position as digit (0..3) and seg (0..5, outer ring a..f only), giving 24 positions; linear index = digit*6 + seg.
REQ-013 SHALL transition IDLE->RUN on iSTART && !iSTOP: position := 0; prescaler loaded with (BASE_TICK>>iSPEED)-1.
REQ-014 SHALL transition RUN->PAUSE when iHOLD=1, and PAUSE->RUN when iHOLD=0; the prescaler and position are frozen in PAUSE.
REQ-015 SHALL transition RUN/PAUSE->IDLE on iSTOP; iSTOP has priority over iSTART and iHOLD in the same cycle.
REQ-016 SHALL ignore iSTART in RUN or PAUSE.
REQ-017 SHALL decrement the prescaler each RUN cycle; at 0, SHALL step the position and reload it from the current iSPEED.
REQ-018 SHALL sample iDIR at each step: forward index+1, reverse index-1.
REQ-019 SHALL wrap the index forward 23->0 and reverse 0->23; either wrap SHALL pulse oWRAP for exactly the step cycle.
REQ-020 SHALL drive the selected digit as 7'h7F with bit[seg] cleared and all other digits 7'h7F while in RUN or PAUSE; in IDLE all digits SHALL be 7'h7F.
REQ-021 SHALL register the oHEX outputs so that they reflect the state/position one clock after that state/position changes.
REQ-022 SHALL update oBUSY in the same cycle as the state register.

Reset
REQ-023 SHALL, on iRST_N low, force state IDLE, position 0, prescaler 0, oHEX0_D..oHEX3_D = 7'h7F, oBUSY = 0, oWRAP = 0, immediately and independent of the clock.
REQ-024 SHALL, when reset is asserted mid-chase, discard the position; the first chase after release SHALL require a new iSTART.

Configuration
REQ-025 SHALL recognise the macro SEG_CHASE_TRAIL_EN; when defined, the previous position (index-1 forward, index+1 reverse, mod 24) SHALL also be lit, forming a 2-segment snake.
REQ-026 SHALL, with SEG_CHASE_TRAIL_EN defined, suppress the trail until the first step after iSTART, and clear the trail on direction change until the next step.
REQ-027 SHALL, without SEG_CHASE_TRAIL_EN, light only a single segment and contain no trail registers.

Structure
REQ-028 SHALL place in package seg_chase_pkg: the state enum (IDLE/RUN/PAUSE), NUM_DIGITS=4, SEGS_PER_DIGIT=6, NUM_POS=24, and HEX_BLANK=7'h7F.
REQ-029 SHALL implement position-to-segment decoding in one combinational sub-module, seg_pos_decode (inputs: index, enable, trail index, trail valid; output: four 7-bit digits), instantiated once.

Verification
REQ-030 SHALL cover, with BASE_TICK=8, iSPEED=0: an iSTART pulse -> oBUSY=1 next cycle, oHEX0_D=7'h7E, then one step every 8 cycles; after 24 steps oHEX0_D=7'h7E again and oWRAP pulsed once.
REQ-031 SHALL cover reverse from start (iDIR=1) -> first step gives index 23: oHEX3_D=7'h5F, oWRAP=1 for one cycle.
REQ-032 SHALL cover iHOLD high for 20 cycles mid-step -> outputs frozen and step resumes with the remaining prescaler count; iSPEED=2 -> period of 2 cycles.
REQ-033 SHALL cover iSTART and iSTOP asserted together in RUN -> IDLE, all oHEX=7'h7F, oBUSY=0.
REQ-034 SHALL cover iRST_N dropped mid-chase -> outputs blank asynchronously; after release, no movement until iSTART.
REQ-035 SHALL cover, with SEG_CHASE_TRAIL_EN defined, the second step forward -> oHEX0_D=7'h79 (seg b and seg c lit).

Source files
------------

// File: rtl/seg_chase_pkg.sv
// Shared types, geometry constants and index helpers for the segment chase
// controller. The 24 chase positions run over the outer ring (a..f) of four
// seven-segment digits; linear index = digit*6 + seg.
package seg_chase_pkg;

  localparam int NUM_DIGITS     = 4;
  localparam int SEGS_PER_DIGIT = 6;
  localparam int NUM_POS        = NUM_DIGITS * SEGS_PER_DIGIT;

  // Active-low segment drives: all ones means every segment is dark.
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  typedef logic [4:0] pos_idx_t;
  typedef logic [1:0] digit_t;
  typedef logic [2:0] seg_t;

  // Linear index from digit/segment coordinates.
  function automatic pos_idx_t pos_index(input digit_t digit, input seg_t seg);
    return (5'(digit) * 5'd6) + 5'(seg);
  endfunction

  // Digit holding a linear index.
  function automatic digit_t idx_digit(input pos_idx_t idx);
    return 2'(idx / 5'd6);
  endfunction

  // Segment (0 = a .. 5 = f) of a linear index within its digit.
  function automatic seg_t idx_seg(input pos_idx_t idx);
    return 3'(idx % 5'd6);
  endfunction

  // Position the chase came from: one behind in the direction of travel.
  function automatic pos_idx_t idx_behind(input pos_idx_t idx, input logic rev);
    pos_idx_t r;
    if (rev) r = (idx == 5'(NUM_POS - 1)) ? 5'd0 : idx + 5'd1;
    else     r = (idx == 5'd0) ? 5'(NUM_POS - 1) : idx - 5'd1;
    return r;
  endfunction

endpackage

// File: rtl/seg_pos_decode.sv
// Combinational position-to-segment decoder: turns a head index (and an
// optional trail index) into four active-low seven-segment digit patterns.
module seg_pos_decode
  import seg_chase_pkg::*;
(
  input  pos_idx_t                      idx_i,
  input  logic                          en_i,
  input  pos_idx_t                      trail_idx_i,
  input  logic                          trail_vld_i,
  output logic [NUM_DIGITS-1:0][6:0]    digits_o
);

  // Start from a blank display and clear the lit segment bits.
  // NOTE: every output gets a default at the top of the always_comb so no
  // path leaves it unassigned, which is what keeps latches from being inferred.
  always_comb begin
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digits_o[d] = HEX_BLANK;
    end
    if (en_i) begin
      digits_o[idx_digit(idx_i)][idx_seg(idx_i)] = 1'b0;
      if (trail_vld_i) begin
        digits_o[idx_digit(trail_idx_i)][idx_seg(trail_idx_i)] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_chase_ctrl.sv
// Segment chase controller: walks one lit segment around the outer ring of
// four seven-segment digits, one step every (BASE_TICK >> iSPEED) clocks.
// Optional feature macro: SEG_CHASE_TRAIL_EN -- when defined, the position
// just behind the head is also lit, forming a two-segment snake.
module seg_chase_ctrl
  import seg_chase_pkg::*;
#(
  parameter int BASE_TICK = 12_500_000
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic       iSTOP,
  input  logic       iHOLD,
  input  logic       iDIR,
  input  logic [1:0] iSPEED,
  output logic [6:0] oHEX0_D,
  output logic [6:0] oHEX1_D,
  output logic [6:0] oHEX2_D,
  output logic [6:0] oHEX3_D,
  output logic       oBUSY,
  output logic       oWRAP
);

  localparam int PW = $clog2(BASE_TICK + 1);

  state_e                       state_q, state_d;
  digit_t                       digit_q, digit_d;
  seg_t                         seg_q, seg_d;
  logic [PW-1:0]                presc_q, presc_d;
  logic                         wrap_q, wrap_d;
  logic                         busy_q;
  logic [NUM_DIGITS-1:0][6:0]   hex_q;

  logic                         start_go;
  logic                         count_go;
  logic                         step_go;
  logic [PW-1:0]                reload_val;
  pos_idx_t                     cur_idx;
  pos_idx_t                     trail_idx;
  logic                         trail_vld;
  logic [NUM_DIGITS-1:0][6:0]   dec_digits;

  // Prescaler reload tracks the live speed setting at every reload point.
  assign reload_val = (PW'(BASE_TICK) >> iSPEED) - PW'(1);

  // Stop wins over start/hold; counting only happens in an undisturbed RUN cycle.
  assign start_go = (state_q == IDLE) && iSTART && !iSTOP;
  assign count_go = (state_q == RUN) && !iSTOP && !iHOLD;
  assign step_go  = count_go && (presc_q == '0);

  assign cur_idx  = pos_index(digit_q, seg_q);

  // FSM next-state: IDLE -> RUN on start, RUN <-> PAUSE on hold, any -> IDLE on stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = RUN;
      RUN: begin
        if (iSTOP)      state_d = IDLE;
        else if (iHOLD) state_d = PAUSE;
      end
      PAUSE: begin
        if (iSTOP)       state_d = IDLE;
        else if (!iHOLD) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler and position: restart at 0 on start, step on prescaler expiry.
  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    seg_d   = seg_q;
    wrap_d  = 1'b0;
    if (start_go) begin
      presc_d = reload_val;
      digit_d = '0;
      seg_d   = '0;
    end else if (step_go) begin
      presc_d = reload_val;
      if (!iDIR) begin
        if (seg_q == 3'(SEGS_PER_DIGIT - 1)) begin
          seg_d   = '0;
          digit_d = digit_q + 2'd1;
          wrap_d  = (digit_q == 2'(NUM_DIGITS - 1));
        end else begin
          seg_d   = seg_q + 3'd1;
        end
      end else begin
        if (seg_q == 3'd0) begin
          seg_d   = 3'(SEGS_PER_DIGIT - 1);
          digit_d = digit_q - 2'd1;
          wrap_d  = (digit_q == 2'd0);
        end else begin
          seg_d   = seg_q - 3'd1;
        end
      end
    end else if (count_go) begin
      presc_d = presc_q - PW'(1);
    end
  end

  // Core state registers, cleared asynchronously so a reset discards the chase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      digit_q <= '0;
      seg_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef SEG_CHASE_TRAIL_EN
  logic trail_vld_q, trail_vld_d;
  logic trail_dir_q, trail_dir_d;

  // Trail appears after the first step and vanishes on a direction change
  // until the next step re-establishes where the head came from.
  always_comb begin
    trail_vld_d = trail_vld_q;
    trail_dir_d = trail_dir_q;
    if (state_q == IDLE) begin
      if (start_go) begin
        trail_vld_d = 1'b0;
        trail_dir_d = iDIR;
      end
    end else if (step_go) begin
      trail_vld_d = 1'b1;
      trail_dir_d = iDIR;
    end else if (iDIR != trail_dir_q) begin
      trail_vld_d = 1'b0;
    end
  end

  // Trail bookkeeping registers.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      trail_vld_q <= 1'b0;
      trail_dir_q <= 1'b0;
    end else begin
      trail_vld_q <= trail_vld_d;
      trail_dir_q <= trail_dir_d;
    end
  end

  assign trail_idx = idx_behind(cur_idx, trail_dir_q);
  assign trail_vld = trail_vld_q;
`else
  assign trail_idx = cur_idx;
  assign trail_vld = 1'b0;
`endif

  seg_pos_decode u_decode (
    .idx_i       (cur_idx),
    .en_i        (state_q != IDLE),
    .trail_idx_i (trail_idx),
    .trail_vld_i (trail_vld),
    .digits_o    (dec_digits)
  );

  // Registered segment drives: one clock behind state/position.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        hex_q[d] <= HEX_BLANK;
      end
    end else begin
      hex_q <= dec_digits;
    end
  end

  assign oHEX0_D = hex_q[0];
  assign oHEX1_D = hex_q[1];
  assign oHEX2_D = hex_q[2];
  assign oHEX3_D = hex_q[3];
  assign oBUSY   = busy_q;
  assign oWRAP   = wrap_q;

endmodule
